mio_bus_responder: RTL and testbench
====================================

// Module: mio_bus_responder
// PURPOSE
//  Memory/IO responder on the CPU side of the MIO bus. Serves the multicycle CPU's memory port.
//  Decodes the CPU address into data RAM, LED register, switch input or free-running counter.
//  Sequences the wait-stated RAM access and drives mio_ready and cpu_rdata back to the CPU.
//  mio_ready gates the CPU's PC and IR updates, so it must be low while an access is in flight.
// PARAMETERS
//  RAM_AW        10  RAM word-address width; RAM is 2^RAM_AW 32-bit words at 0x0000_0000
//  RAM_WAIT      1   extra cycles between RAM address issue and ram_rdata valid (0..7)
//  LED_W         8   width of the LED output register
//  SW_W          16  width of the switch input
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       synchronous, active-high reset
//  cpu_req    in   1       access request; held high by CPU until mio_ready completes it
//  cpu_we     in   1       1 = write, 0 = read; stable while cpu_req high
//  cpu_addr   in   32      byte address; addr[1:0] ignored (word access only)
//  cpu_wdata  in   32      write data; stable while cpu_req high
//  cpu_rdata  out  32      read data; valid in the cycle mio_ready completes a read
//  mio_ready  out  1       high = bus idle or access completing this cycle
//  ram_addr   out  RAM_AW  RAM word address (= cpu_addr[RAM_AW+1:2])
//  ram_wdata  out  32      RAM write data
//  ram_we     out  1       RAM write strobe, exactly one cycle per write
//  ram_rdata  in   32      RAM read data, valid RAM_WAIT+1 cycles after ram_addr issued
//  sw_in      in   SW_W    switch inputs (asynchronous; 2-flop synchronised internally)
//  led_out    out  LED_W   LED register
// BEHAVIOUR
//  Address map: RAM 0x0000_0000..(4<<RAM_AW)-1; LED 0xE000_0000 (RW); SW 0xF000_0000 (RO,
//   zero-extended); CNT 0xF000_0004 (RW). Anything else is unmapped: reads return 0,
//   writes are dropped, and the access still completes (never hangs).
//  FSM states: IDLE, ISSUE, WAIT, DONE. cpu_req is sampled only in IDLE.
//   IDLE -(cpu_req)-> ISSUE.
//   ISSUE, RAM read with RAM_WAIT>0 -> WAIT; every other case -> DONE.
//   WAIT counts RAM_WAIT cycles -> DONE. DONE -> IDLE unconditionally.
//  mio_ready = (state==IDLE && !cpu_req) || state==DONE. It is decoded from registered state,
//   so it drops in the same cycle cpu_req rises.
//  Latency from first cpu_req cycle to the mio_ready pulse:
//   RAM read: RAM_WAIT+2 cycles. All writes and all peripheral reads: 2 cycles.
//  ISSUE drives ram_addr/ram_wdata. ram_we=1 in ISSUE only, and only for RAM writes.
//  ram_addr/ram_wdata are registered and hold their values through WAIT.
//  cpu_rdata is registered: loaded on entry to DONE for reads, otherwise holds its last value.
//  A CPU that keeps cpu_req high after DONE starts a new access. Back-to-back accesses
//   therefore cost one extra IDLE cycle, in which mio_ready=0.
//  CNT increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
//   A CNT write in ISSUE loads cpu_wdata; the write wins over the increment in that cycle.
//   A CNT read returns the value captured in ISSUE.
//  LED write loads cpu_wdata[LED_W-1:0] in ISSUE.
//  Reset values: state IDLE; cpu_rdata 0; led_out 0; CNT 0; ram_we 0; ram_addr 0;
//   ram_wdata 0; sync flops 0. mio_ready therefore = !cpu_req during and after reset.
//  Reset mid-access aborts the access: no ram_we pulse and no mio_ready pulse for it.
//   The CPU is reset together with this block.
// STRUCTURE
//  mio_pkg: address-map base/mask constants, region enum (RGN_RAM/LED/SW/CNT/NONE),
//   FSM state encoding.
//  Sub-module mio_addr_decode: combinational cpu_addr -> region. The decoded region is
//   registered in IDLE->ISSUE so it stays stable for the whole access.
//  Everything else (FSM, wait counter, peripheral registers, SW synchroniser) is in this module.
// TESTING
//  1 Reset with cpu_req=0 -> mio_ready=1, led_out=0, cpu_rdata=0, ram_we never pulses.
//  2 Write 0x0000_0010 <- 0xDEADBEEF -> ram_we one cycle, ram_addr=4, mio_ready at cycle 2;
//    then read 0x10 with RAM_WAIT=1 -> mio_ready at cycle 3, cpu_rdata=0xDEADBEEF.
//  3 Write LED 0xE000_0000 <- 0x1A5 -> led_out=0xA5 (LED_W=8); sw_in=0x1234 then read
//    0xF000_0000 -> cpu_rdata=0x0000_1234.
//  4 Write CNT <- 0xFFFF_FFFE, idle 3 cycles, read CNT -> value has wrapped through 0;
//    bench checks it against a cycle-exact model.
//  5 Read unmapped 0x8000_0000 -> cpu_rdata=0 and mio_ready at cycle 2;
//    write there -> no ram_we, no LED change.
//  6 Assert reset in WAIT of a RAM read -> no mio_ready pulse for it, state IDLE,
//    next access behaves normally.
//  Continuous assertions: mio_ready=0 in ISSUE/WAIT; at most one ram_we per request;
//   cpu_req never leaves a request unserved.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: address map, decoded regions and FSM states.
package mio_pkg;

    localparam logic [31:0] LED_ADDR = 32'hE000_0000;
    localparam logic [31:0] SW_ADDR  = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR = 32'hF000_0004;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_LED,
        RGN_SW,
        RGN_CNT
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic word_match(input logic [31:2] word_addr, input logic [31:0] base);
        return word_addr == base[31:2];
    endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational CPU word-address decoder; anything outside the map falls to RGN_NONE.
module mio_addr_decode
    import mio_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic [31:2] word_addr,
    output region_t     region
);

    always_comb begin
        region = RGN_NONE;
        if (word_addr[31:RAM_AW+2] == '0) begin
            region = RGN_RAM;
        end else if (word_match(word_addr, LED_ADDR)) begin
            region = RGN_LED;
        end else if (word_match(word_addr, SW_ADDR)) begin
            region = RGN_SW;
        end else if (word_match(word_addr, CNT_ADDR)) begin
            region = RGN_CNT;
        end
    end

endmodule

// File: rtl/mio_bus_responder.sv
// CPU-side MIO responder: sequences wait-stated RAM accesses and serves LED, switch and counter
// registers, handshaking with the CPU through mio_ready.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int RAM_AW   = 10,
    parameter int RAM_WAIT = 1,
    parameter int LED_W    = 8,
    parameter int SW_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              mio_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [SW_W-1:0]   sw_in,
    output logic [LED_W-1:0]  led_out
);

    localparam logic [2:0] WAIT_LAST = 3'(RAM_WAIT > 0 ? RAM_WAIT - 1 : 0);

    state_t          state, next_state;
    region_t         decoded_region, region;
    logic            is_write;
    logic [2:0]      wait_cnt;
    logic [31:0]     cnt;
    logic [SW_W-1:0] sw_meta, sw_sync;
    logic            accept, enter_done;
    logic [31:0]     read_value;
    logic            unused_byte_offset;

    assign unused_byte_offset = ^cpu_addr[1:0];

    mio_addr_decode #(.RAM_AW(RAM_AW)) u_decode (
        .word_addr(cpu_addr[31:2]),
        .region   (decoded_region)
    );

    // Only RAM reads need the wait state; a cpu_req still high in DONE starts afresh from IDLE.
    always_comb begin
        next_state = state;
        mio_ready  = 1'b0;
        accept     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                mio_ready = !cpu_req;
                if (cpu_req) begin
                    accept     = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (region == RGN_RAM && !is_write && RAM_WAIT > 0) next_state = ST_WAIT;
                else next_state = ST_DONE;
            end
            ST_WAIT: begin
                if (wait_cnt == '0) next_state = ST_DONE;
            end
            ST_DONE: begin
                mio_ready  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign enter_done = (next_state == ST_DONE) && (state != ST_DONE);

    always_comb begin
        read_value = '0;
        unique case (region)
            RGN_RAM: read_value = ram_rdata;
            RGN_LED: read_value = 32'(led_out);
            RGN_SW:  read_value = 32'(sw_sync);
            RGN_CNT: read_value = cnt;
            default: read_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            region   <= RGN_NONE;
            is_write <= 1'b0;
            wait_cnt <= '0;
            ram_addr <= '0;
            ram_wdata <= '0;
            ram_we   <= 1'b0;
        end else begin
            state  <= next_state;
            ram_we <= 1'b0;
            if (accept) begin
                region    <= decoded_region;
                is_write  <= cpu_we;
                ram_addr  <= cpu_addr[RAM_AW+1:2];
                ram_wdata <= cpu_wdata;
                ram_we    <= cpu_we && (decoded_region == RGN_RAM);
            end
            if (state == ST_ISSUE) wait_cnt <= WAIT_LAST;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Peripheral writes take the data latched at accept, so they land at the end of ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            led_out   <= '0;
            cpu_rdata <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (state == ST_ISSUE && is_write && region == RGN_CNT) cnt <= ram_wdata;
            else cnt <= cnt + 32'd1;
            if (state == ST_ISSUE && is_write && region == RGN_LED) led_out <= ram_wdata[LED_W-1:0];
            if (enter_done && !is_write) cpu_rdata <= read_value;
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: directed vector table, multi-cycle corner sequences,
// and randomized accesses against a cycle-counting reference model.
module tb_mio_bus_responder;

    localparam int RAM_AW    = 10;
    localparam int RAM_WAIT  = 1;
    localparam int LED_W     = 8;
    localparam int SW_W      = 16;
    localparam int RAM_WORDS = 1 << RAM_AW;
    localparam logic [31:0] RAM_BYTES = 32'(4 << RAM_AW);
    localparam int RD_LAT    = RAM_WAIT + 2;
    localparam int PIPE_IDX  = (RAM_WAIT > 0) ? RAM_WAIT - 1 : 0;
    localparam int RG_NONE = 0, RG_RAM = 1, RG_LED = 2, RG_SW = 3, RG_CNT = 4;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              mio_ready;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic [SW_W-1:0]   sw_in;
    logic [LED_W-1:0]  led_out;

    int vecCount  = 0;
    int missCount = 0;
    int edgeCount = 0;

    mio_bus_responder #(
        .RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT), .LED_W(LED_W), .SW_W(SW_W)
    ) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .mio_ready(mio_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata), .sw_in(sw_in), .led_out(led_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // RAM device: read data becomes valid RAM_WAIT+1 edges after the address appears.
    logic [31:0] ramMem  [0:RAM_WORDS-1];
    logic [31:0] ramPipe [0:7];
    always @(posedge clk) begin
        if (ram_we) ramMem[ram_addr] <= ram_wdata;
        ramPipe[0] <= ramMem[ram_addr];
        for (int k = 1; k < 8; k++) ramPipe[k] <= ramPipe[k-1];
    end
    assign ram_rdata = (RAM_WAIT == 0) ? ramMem[ram_addr] : ramPipe[PIPE_IDX];

    // Reference model state
    logic [31:0]      refMem [0:RAM_WORDS-1];
    logic [LED_W-1:0] refLed;
    logic [SW_W-1:0]  refSw;
    logic [31:0]      cntBase;
    int               cntBaseEdge;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        int          expLat;
        int          expWes;
        logic [31:0] expLed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] expRdata, input int expLat, input int expWes,
                                   input logic [31:0] expLed);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.expRdata = expRdata;
        v.expLat = expLat; v.expWes = expWes; v.expLed = expLed;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    function automatic int regionOf(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < RAM_BYTES) return RG_RAM;
        if (w == 32'hE000_0000) return RG_LED;
        if (w == 32'hF000_0000) return RG_SW;
        if (w == 32'hF000_0004) return RG_CNT;
        return RG_NONE;
    endfunction

    // Applies one access and updates the model; CNT value is derived from elapsed edges.
    function automatic void modelAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                        input int n0, output logic [31:0] expRd, output int expLat,
                                        output int expWes);
        logic [RAM_AW-1:0] idx;
        idx    = addr[RAM_AW+1:2];
        expRd  = '0;
        expLat = 2;
        expWes = 0;
        case (regionOf(addr))
            RG_RAM: begin
                if (we) begin
                    refMem[idx] = wdata;
                    expWes = 1;
                end else begin
                    expRd  = refMem[idx];
                    expLat = RD_LAT;
                end
            end
            RG_LED: if (we) refLed = wdata[LED_W-1:0]; else expRd = 32'(refLed);
            RG_SW:  if (!we) expRd = 32'(refSw);
            RG_CNT: begin
                if (we) begin
                    cntBase = wdata;
                    cntBaseEdge = n0 + 2;
                end else begin
                    expRd = cntBase + 32'(n0 + 1 - cntBaseEdge);
                end
            end
            default: expRd = '0;
        endcase
    endfunction

    // Called at a negedge with the bus idle; returns at a negedge with cpu_req dropped.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output int lat, output int wes,
                                 output logic [31:0] weAddr, output logic [31:0] weData, output int n0);
        bit seen;
        n0 = edgeCount;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        lat = -1; wes = 0; weAddr = '0; weData = '0; rdata = '0; seen = 1'b0;
        for (int c = 0; c < 24 && !seen; c++) begin
            #1;
            if (ram_we) begin
                wes++;
                weAddr = 32'(ram_addr);
                weData = ram_wdata;
            end
            if (mio_ready) begin
                seen  = 1'b1;
                lat   = c;
                rdata = cpu_rdata;
            end
            @(negedge clk);
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    logic prevWe = 1'b0;
    always @(negedge clk) begin
        if (!reset) checkOutput("ramWeSingle", {31'b0, ram_we & prevWe}, 32'h0);
        prevWe = ram_we;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd, wa, wd, expRd;
        int lat, wes, n0, expLat, expWes, kind;
        logic [5:0] b2bPat;

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; sw_in = '0;
        for (int i = 0; i < RAM_WORDS; i++) begin
            ramMem[i] = '0;
            refMem[i] = '0;
        end
        for (int k = 0; k < 8; k++) ramPipe[k] = '0;

        // Reset with cpu_req low
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("rst%0d.ready", c), {31'b0, mio_ready}, 32'h1);
            checkOutput($sformatf("rst%0d.led", c), 32'(led_out), 32'h0);
            checkOutput($sformatf("rst%0d.rdata", c), cpu_rdata, 32'h0);
            checkOutput($sformatf("rst%0d.we", c), {31'b0, ram_we}, 32'h0);
            @(negedge clk);
        end
        reset = 1'b0;
        cntBase = '0; cntBaseEdge = edgeCount; refLed = '0;
        sw_in = 16'h1234; refSw = sw_in;
        repeat (3) @(negedge clk);

        // Directed vector table
        vecs.push_back(mkVec(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         2,      1, 32'h00));
        vecs.push_back(mkVec(1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, RD_LAT, 0, 32'h00));
        vecs.push_back(mkVec(1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, RD_LAT, 0, 32'h00));
        vecs.push_back(mkVec(1'b1, 32'hE000_0000, 32'h0000_01A5, 32'h0,         2,      0, 32'hA5));
        vecs.push_back(mkVec(1'b0, 32'hE000_0000, 32'h0,         32'h0000_00A5, 2,      0, 32'hA5));
        vecs.push_back(mkVec(1'b0, 32'hF000_0000, 32'h0,         32'h0000_1234, 2,      0, 32'hA5));
        vecs.push_back(mkVec(1'b0, 32'h8000_0000, 32'h0,         32'h0,         2,      0, 32'hA5));
        vecs.push_back(mkVec(1'b1, 32'h8000_0000, 32'h0000_0055, 32'h0,         2,      0, 32'hA5));
        vecs.push_back(mkVec(1'b1, 32'h0000_0FFC, 32'h1234_5678, 32'h0,         2,      1, 32'hA5));
        vecs.push_back(mkVec(1'b0, 32'h0000_0FFC, 32'h0,         32'h1234_5678, RD_LAT, 0, 32'hA5));
        vecs.push_back(mkVec(1'b0, 32'h0000_1000, 32'h0,         32'h0,         2,      0, 32'hA5));
        vecs.push_back(mkVec(1'b1, 32'h0000_1000, 32'h0000_0009, 32'h0,         2,      0, 32'hA5));
        vecs.push_back(mkVec(1'b0, 32'h0000_0000, 32'h0,         32'h0,         RD_LAT, 0, 32'hA5));
        vecs.push_back(mkVec(1'b1, 32'hE000_0004, 32'h0000_0077, 32'h0,         2,      0, 32'hA5));
        vecs.push_back(mkVec(1'b1, 32'hE000_0003, 32'h0000_003C, 32'h0,         2,      0, 32'h3C));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, wes, wa, wd, n0);
            modelAccess(vecs[i].we, vecs[i].addr, vecs[i].wdata, n0, expRd, expLat, expWes);
            checkOutput($sformatf("v%0d.lat", i), 32'(lat), 32'(vecs[i].expLat));
            checkOutput($sformatf("v%0d.wes", i), 32'(wes), 32'(vecs[i].expWes));
            checkOutput($sformatf("v%0d.led", i), 32'(led_out), vecs[i].expLed);
            if (!vecs[i].we) checkOutput($sformatf("v%0d.rdata", i), rd, vecs[i].expRdata);
            if (vecs[i].expWes == 1) begin
                checkOutput($sformatf("v%0d.ramAddr", i), wa, 32'(vecs[i].addr[RAM_AW+1:2]));
                checkOutput($sformatf("v%0d.ramWdata", i), wd, vecs[i].wdata);
            end
        end

        // Back-to-back: cpu_req held through DONE costs one IDLE cycle with mio_ready low
        b2bPat = 6'b100100;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hE000_0000; cpu_wdata = 32'h0000_005A;
        for (int c = 0; c < 6; c++) begin
            #1;
            checkOutput($sformatf("b2b.ready%0d", c), {31'b0, mio_ready}, {31'b0, b2bPat[c]});
            if (c == 2) cpu_we = 1'b0;
            if (c == 5) checkOutput("b2b.rdata", cpu_rdata, 32'h0000_005A);
            @(negedge clk);
        end
        cpu_req = 1'b0;
        refLed = 8'h5A;

        // Counter write near the top, then a read after it has wrapped
        applyStimulus(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, lat, wes, wa, wd, n0);
        modelAccess(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, n0, expRd, expLat, expWes);
        checkOutput("cnt.wrLat", 32'(lat), 32'h2);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 32'hF000_0004, 32'h0, rd, lat, wes, wa, wd, n0);
        modelAccess(1'b0, 32'hF000_0004, 32'h0, n0, expRd, expLat, expWes);
        checkOutput("cnt.wrapConst", rd, 32'h0000_0003);
        checkOutput("cnt.wrapModel", rd, expRd);

        // Reset during WAIT of a RAM read aborts it
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
        #1 checkOutput("abort.ready0", {31'b0, mio_ready}, 32'h0);
        @(negedge clk);
        #1 checkOutput("abort.ready1", {31'b0, mio_ready}, 32'h0);
        @(negedge clk);
        #1 checkOutput("abort.ready2", {31'b0, mio_ready}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("abort.noReady", {31'b0, mio_ready}, 32'h0);
        checkOutput("abort.rdata", cpu_rdata, 32'h0);
        checkOutput("abort.led", 32'(led_out), 32'h0);
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0;
        cntBase = '0; cntBaseEdge = edgeCount; refLed = '0;
        #1 checkOutput("abort.idleReady", {31'b0, mio_ready}, 32'h1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, rd, lat, wes, wa, wd, n0);
        modelAccess(1'b0, 32'h0000_0010, 32'h0, n0, expRd, expLat, expWes);
        checkOutput("abort.nextLat", 32'(lat), 32'(RD_LAT));
        checkOutput("abort.nextRdata", rd, 32'hDEAD_BEEF);

        // Randomized accesses against the reference model
        for (int i = 0; i < 300; i++) begin
            logic        we;
            logic [31:0] addr, wdata;
            kind  = $urandom_range(0, 5);
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom();
            case (kind)
                0, 5: addr = (32'($urandom_range(0, RAM_WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
                1:    addr = 32'hE000_0000 | 32'($urandom_range(0, 3));
                2: begin
                    addr  = 32'hF000_0000;
                    sw_in = SW_W'($urandom());
                    refSw = sw_in;
                    repeat (3) @(negedge clk);
                end
                3:    addr = 32'hF000_0004;
                default: begin
                    addr = $urandom();
                    addr[31:28] = 4'($urandom_range(4, 13));
                end
            endcase
            applyStimulus(we, addr, wdata, rd, lat, wes, wa, wd, n0);
            modelAccess(we, addr, wdata, n0, expRd, expLat, expWes);
            checkOutput($sformatf("r%0d.lat", i), 32'(lat), 32'(expLat));
            checkOutput($sformatf("r%0d.wes", i), 32'(wes), 32'(expWes));
            checkOutput($sformatf("r%0d.led", i), 32'(led_out), 32'(refLed));
            if (!we) checkOutput($sformatf("r%0d.rdata a=%08h", i, addr), rd, expRd);
            if (expWes == 1) checkOutput($sformatf("r%0d.ramAddr", i), wa, 32'(addr[RAM_AW+1:2]));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
